// File: rtl/lfsr_rr_sched.sv
// lfsr_rr_sched: round-robin scheduler sharing one Galois LFSR (de Bruijn
// extended, so the all-zero state is part of the sequence) among NREQ
// requesters. The LFSR advances only when a word is granted, so each value
// goes to exactly one requester. A reseed reloads seed and taps at run time.
// Optional feature: define LFSR_WRAP_DET_EN to add the `wrap` output, which
// pulses when a granted step returns the LFSR to its seed.
module lfsr_rr_sched #(
    parameter int SIZE = 8,
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] tap,
    input  logic [SIZE-1:0] seed,
    input  logic            reseed,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [SIZE-1:0] rdata,
    output logic            rvalid,
    output logic            busy
`ifdef LFSR_WRAP_DET_EN
    ,
    output logic            wrap
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_SEED = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] lfsr_q, lfsr_d;
    logic [SIZE-1:0] tap_q, tap_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [SIZE-1:0] rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic [SIZE-1:0] lfsr_nxt;
    logic            any_req;
    logic [PW-1:0]   winner;
    logic [PW:0]     scan_idx;
`ifdef LFSR_WRAP_DET_EN
    // The seed copy only feeds the wrap comparator, so it lives with it.
    logic [SIZE-1:0] seed_q, seed_d;
    logic            wrap_q, wrap_d;
`endif

    // All-zeros or all-ones tap masks collapse to a single tap at bit 1.
    function automatic logic [SIZE-1:0] sanitise_tap(input logic [SIZE-1:0] t);
        if (t == '0 || t == '1) begin
            return SIZE'(2);
        end
        return t;
    endfunction

    // One Galois step; the zero-detect term splices the all-zero state into
    // the cycle. Tap bit 0 has no effect because bit 0 always takes fb.
    function automatic logic [SIZE-1:0] lfsr_step(input logic [SIZE-1:0] s,
                                                  input logic [SIZE-1:0] t);
        logic            fb;
        logic [SIZE-1:0] n;
        fb   = s[SIZE-1] ^ (s[SIZE-2:0] == '0);
        n    = '0;
        n[0] = fb;
        for (int b = 1; b < SIZE; b++) begin
            n[b] = t[b] ? (s[b-1] ^ fb) : s[b-1];
        end
        return n;
    endfunction

    // Pick the first requesting index at or after the pointer, wrapping.
    always_comb begin
        any_req  = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = {1'b0, ptr_q} + (PW + 1)'(i);
            if (scan_idx >= (PW + 1)'(NREQ)) begin
                scan_idx = scan_idx - (PW + 1)'(NREQ);
            end
            if (!any_req && req[scan_idx[PW-1:0]]) begin
                any_req = 1'b1;
                winner  = scan_idx[PW-1:0];
            end
        end
    end

    // Next-state and registered-output logic for the SEED/RUN controller.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        tap_d    = tap_q;
        ptr_d    = ptr_q;
        gnt_d    = '0;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        lfsr_nxt = lfsr_step(lfsr_q, tap_q);
`ifdef LFSR_WRAP_DET_EN
        seed_d   = seed_q;
        wrap_d   = 1'b0;
`endif
        case (state_q)
            ST_SEED: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (reseed) begin
                    // Reseed wins over a same-cycle request; the request stays pending.
                    lfsr_d  = seed;
                    tap_d   = sanitise_tap(tap);
`ifdef LFSR_WRAP_DET_EN
                    seed_d  = seed;
`endif
                    state_d = ST_SEED;
                end else if (any_req) begin
                    gnt_d    = NREQ'(1) << winner;
                    rdata_d  = lfsr_q;
                    rvalid_d = 1'b1;
                    lfsr_d   = lfsr_nxt;
                    ptr_d    = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
`ifdef LFSR_WRAP_DET_EN
                    wrap_d   = (lfsr_nxt == seed_q);
`endif
                end
            end
            default: begin
                state_d = ST_SEED;
            end
        endcase
    end

    // State and output registers; reset performs the reseed loads plus clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_SEED;
            lfsr_q   <= seed;
            tap_q    <= sanitise_tap(tap);
            ptr_q    <= '0;
            gnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
`ifdef LFSR_WRAP_DET_EN
            seed_q   <= seed;
            wrap_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            tap_q    <= tap_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
`ifdef LFSR_WRAP_DET_EN
            seed_q   <= seed_d;
            wrap_q   <= wrap_d;
`endif
        end
    end

    assign gnt    = gnt_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign busy   = (state_q == ST_SEED);
`ifdef LFSR_WRAP_DET_EN
    assign wrap   = wrap_q;
`endif

endmodule

// File: doc/lfsr_rr_sched.md
# lfsr_rr_sched

Round-robin scheduler that shares one pseudo-random generator among `NREQ` requesters. It embeds a de Bruijn–extended Galois LFSR that advances only when a word is delivered, so every word goes to exactly one requester and no sequence value is lost or duplicated. A reseed input reloads the LFSR and taps at run time. The block sits between the shared random source and its consumers, for example test-pattern, dither or backoff generators.

## Interface
- `SIZE`, default 8: LFSR width in bits; must be ≥ 3.
- `NREQ`, default 4: number of requesters; must be ≥ 2.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tap`  in  SIZE  Galois tap mask; sampled only at `rst` and at reseed.
- `seed`  in  SIZE  initial LFSR state; sampled only at `rst` and at reseed.
- `reseed`  in  1  single-cycle request to reload `seed` and `tap`.
- `req`  in  NREQ  level request per requester.
- `gnt`  out  NREQ  registered one-hot grant; pulses high for one cycle per delivered word.
- `rdata`  out  SIZE  random word, valid while `rvalid` is high.
- `rvalid`  out  1  high in the same cycle as any `gnt` bit.
- `busy`  out  1  high while in state SEED.
- `wrap`  out  1  present only with `LFSR_WRAP_DET_EN`; see Configuration.

## Operation
- **Internal registers:**
  - `lfsr_q` (SIZE bits)
  - `tap_q` (SIZE bits)
  - `seed_q` (SIZE bits)
  - `ptr` (priority pointer, ⌈log2 NREQ⌉ bits)
  - `state`
- **Tap sanitising at load:**
  - If `tap` is all-zeros or all-ones, `tap_q` is loaded with 2 (bit 1 set only).
  - Otherwise `tap_q` is loaded with `tap`.
  - `tap_q[0]` is ignored.
- **LFSR step:**
  - `fb = lfsr_q[SIZE-1] ^ (lfsr_q[SIZE-2:0] == 0)`.
  - `next[0] = fb`.
  - For b = 1..SIZE-1: `next[b] = tap_q[b] ? lfsr_q[b-1]^fb : lfsr_q[b-1]`.
  - The all-zero state is part of the sequence. With primitive taps the period is 2^SIZE.
- **States:**
  - **SEED** (one cycle): `busy` = 1, `gnt` = 0, `rvalid` = 0, and `req` is ignored. Next state is RUN.
  - **RUN:**
    - If `reseed` = 1: load `lfsr_q` ← `seed`, `tap_q` ← sanitised `tap`, `seed_q` ← `seed`; go to SEED. `ptr` is unchanged.
    - Else if any `req` bit is set: the winner is the first set bit at or after `ptr`, scanning upward and wrapping from NREQ-1 to 0. Then:
      - `gnt` ← onehot(winner), `rdata` ← `lfsr_q`, `rvalid` ← 1
      - `lfsr_q` ← next
      - `ptr` ← (winner+1) mod NREQ
    - Else: `gnt` ← 0 and `rvalid` ← 0; `lfsr_q` holds.
- **Handshake:**
  - `req` is a level. A requester keeps it high until it sees its `gnt` bit.
  - A requester that keeps `req` high after a grant is served again only after every other pending requester has been served.
  - `rdata` holds its last value when `rvalid` = 0.
- **Reset:** `rst` has priority over everything. It performs the same loads as a reseed and enters SEED. It also sets `ptr` = 0, `gnt` = 0, `rvalid` = 0, `rdata` = 0 and `wrap` = 0. `busy` = 1 in the first cycle after reset.
- **Reset or reseed mid-stream:** any grant pending in that cycle is dropped. No word is issued, and the LFSR value is not consumed.

## Timing
- **Grant latency:** `req` sampled at edge N (in RUN, no `reseed`) → `gnt`/`rvalid`/`rdata` valid in the cycle after edge N.
- **Throughput:** one word per cycle while any `req` is pending. With back-to-back grants, `rdata` steps through consecutive LFSR states.
- **Reseed:**
  - `reseed` at edge N → SEED in the cycle after N.
  - The earliest grant is visible in the cycle after edge N+2. That word equals the new `seed`.
- **Simultaneous `reseed` and `req`:** reseed wins; the request stays pending.
- **`reseed` while in SEED:** ignored.
- **`ptr` wrap-around:** winner NREQ-1 sets `ptr` = 0.

## Configuration
- **`LFSR_WRAP_DET_EN` defined:**
  - The `wrap` port and logic exist.
  - `wrap` pulses for one cycle, aligned with `rvalid`, when the granted step returns the LFSR to `seed_q`, i.e. next == `seed_q`.
  - `wrap` resets to 0.
- **`LFSR_WRAP_DET_EN` undefined:** the `wrap` port and its comparator are absent. All other behaviour is identical.

## Test plan
- **Basic sequence:** SIZE=4, NREQ=4, `rst` with seed=4'b0001, tap=4'b0011, then `req[0]` held high → `rdata` = 0001, 0010, 0100, 1000, 0000, 0011 on consecutive cycles, `gnt` = 0001 each cycle.
- **Tap sanitising:** repeat the basic sequence with tap=4'b1111, and again with tap=4'b0000 → identical `rdata` sequence.
- **Round-robin:** `req` = 4'b1011 held → `gnt` = 0001, 0010, 1000, 0001, … and `rdata` advances one state per grant.
- **Reseed priority:** `reseed` with seed=4'b1000 asserted in the same cycle as `req` = 4'b0001 → no grant, one cycle of `busy`=1, then `gnt` = 0001 with `rdata` = 1000, then 0000.
- **Wrap detection:** with `LFSR_WRAP_DET_EN` defined, seed=0001, tap=0011, `req[2]` held → `wrap` pulses exactly on the 16th grant and every 16th grant thereafter; all 16 values are distinct.
- **Mid-stream reset:** `rst` asserted during back-to-back grants → `gnt`, `rvalid` and `rdata` are 0 in the next cycle, then `busy`=1. After that the first grant goes to the lowest set `req` bit (`ptr` = 0) and carries `seed`.
